alarm_mode_ctrl: RTL and testbench
==================================

ALARM_MODE_CTRL -- requirements
Module: alarm_mode_ctrl

Interface
REQ-001 Parameter RING_TICKS, default 60, sec_tick pulses an alarm rings before auto-stop (1..255).
REQ-002 Parameter SNOOZE_TICKS, default 120, sec_tick pulses between snooze and re-ring (1..1023).
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-005 up, down, left, right, center  in  1 each  debounced single-cycle button pulses.
REQ-006 sec_tick  in  1  single-cycle pulse, once per second.
REQ-007 time_match  in  1  level, high while current HH:MM equals alarm HH:MM.
REQ-008 mode  out  3  current mode: N=0, TH=1, TM=2, AH=3, AM=4.
REQ-009 en_th, en_tm, en_ah, en_am  out  1 each  single-cycle adjust pulse to the matching counter.
REQ-010 updown  out  1  adjust direction, 1=increment, 0=decrement; valid with any en_* pulse.
REQ-011 time_run  out  1  timekeeping counter enable.
REQ-012 armed, ring  out  1 each  alarm armed, alarm sounding.
REQ-013 blink_mask  out  4  per-digit blank request [3:0]=TH1,TH2,TM1,TM2.

Function
REQ-014 Mode FSM: N --center--> TH; in TH/TM/AH/AM, right advances TH->TM->AH->AM->TH, left reverses; center returns to N.
REQ-015 Button priority per cycle: center > left/right > up/down; lower-priority pulses in the same cycle are discarded.
REQ-016 Simultaneous left+right, or up+down, are ignored as a pair.
REQ-017 In TH/TM/AH/AM, up or down registers a one-cycle pulse on the en_* matching mode, one cycle after the button pulse, updown=1 for up, 0 for down.
REQ-018 At most one en_* is high in any cycle; none high in mode N.
REQ-019 time_run=1 only when mode is N, AH or AM; 0 in TH and TM.
REQ-020 In mode N with ring=0: up sets armed, down clears armed; left/right have no effect.
REQ-021 ring asserts the cycle after a rising edge of time_match while armed=1 and mode=N; a level held high does not retrigger.
REQ-022 While ring=1, any button pulse clears ring and is consumed (no mode, arm or adjust effect).
REQ-023 ring self-clears after RING_TICKS sec_tick pulses counted from assertion.
REQ-024 Clearing armed (in any way) clears ring and any pending snooze in the same cycle.
REQ-025 blink phase toggles on each sec_tick; blink_mask = phase ? digit mask of mode (TH=1100, TM=0011, AH=1100, AM=0011) : 0000; N gives 0000.

Reset
REQ-026 On rst=0: mode=N, all en_*=0, updown=0, time_run=1, armed=0, ring=0, blink phase=0, blink_mask=0000, ring/snooze counters=0, time_match edge register=0.
REQ-027 Reset mid-ring or mid-snooze cancels it; no ring on release even if time_match is high.

Configuration
REQ-028 Macro ALARM_SNOOZE_EN defined: center while ring=1 clears ring and starts a snooze counter; after SNOOZE_TICKS sec_ticks ring re-asserts if armed=1, regardless of time_match; other buttons clear ring without snooze.
REQ-029 Macro ALARM_SNOOZE_EN undefined: no snooze counter is built; center behaves as any other button per REQ-022.

Structure
REQ-030 Shared package alarm_pkg holds the mode codes N/TH/TM/AH/AM and digit-mask constants.
REQ-031 Sub-module alarm_ring_timer implements the ring duration and snooze tick counters.

Verification
REQ-032 Reset, then center, right x4 -> mode 0,1,2,3,4,1; left from TH -> AM; center -> N.
REQ-033 Mode TM, up then down -> en_tm pulses one cycle each with updown 1 then 0; up+down same cycle -> no en_*.
REQ-034 N, up (armed=1), time_match rises -> ring=1 next cycle; 60 sec_ticks later ring=0; time_match held -> no retrigger.
REQ-035 Ringing, right pulse -> ring=0, mode stays N; with ALARM_SNOOZE_EN, center -> ring=0, re-ring after exactly 120 sec_ticks.
REQ-036 Mode TH, center and up same cycle -> mode N, no en_th; rst=0 mid-ring -> all outputs at reset values.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared mode codes and display digit masks for the alarm clock mode controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    MODE_N  = 3'd0,
    MODE_TH = 3'd1,
    MODE_TM = 3'd2,
    MODE_AH = 3'd3,
    MODE_AM = 3'd4
  } mode_t;

  // Digit order is [3:0] = TH1, TH2, TM1, TM2
  localparam logic [3:0] MASK_HOURS = 4'b1100;
  localparam logic [3:0] MASK_MINS  = 4'b0011;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

  function automatic logic [3:0] digit_mask(input mode_t m);
    case (m)
      MODE_TH, MODE_AH: digit_mask = MASK_HOURS;
      MODE_TM, MODE_AM: digit_mask = MASK_MINS;
      default:          digit_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_if.sv
// Button/tick inputs and mode/adjust/alarm outputs of the alarm mode controller.
interface alarm_mode_ctrl_if;
  logic       up, down, left, right, center;
  logic       sec_tick;
  logic       time_match;
  logic [2:0] mode;
  logic       en_th, en_tm, en_ah, en_am;
  logic       updown;
  logic       time_run;
  logic       armed, ring;
  logic [3:0] blink_mask;

  modport master (
    output up, down, left, right, center, sec_tick, time_match,
    input  mode, en_th, en_tm, en_ah, en_am, updown, time_run, armed, ring, blink_mask
  );

  modport slave (
    input  up, down, left, right, center, sec_tick, time_match,
    output mode, en_th, en_tm, en_ah, en_am, updown, time_run, armed, ring, blink_mask
  );
endinterface

// File: rtl/alarm_ring_timer.sv
// Ring duration counter and (with ALARM_SNOOZE_EN defined) the snooze countdown.
module alarm_ring_timer #(
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 120
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_tick,
  input  logic ring,
  input  logic ring_start,
  input  logic snooze_start,
  input  logic cancel,
  output logic ring_expire,
  output logic snooze_expire
);

  logic [7:0] ring_cnt;

  // Counts ticks seen while ringing; parked at zero whenever the alarm is silent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ring_cnt <= '0;
    else if (!ring)
      ring_cnt <= '0;
    else if (sec_tick)
      ring_cnt <= ring_cnt + 8'd1;
  end

  assign ring_expire = ring && sec_tick && (ring_cnt == 8'(RING_TICKS - 1));

`ifdef ALARM_SNOOZE_EN
  logic       snoozing;
  logic [9:0] snz_cnt;

  assign snooze_expire = snoozing && sec_tick && (snz_cnt == 10'(SNOOZE_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snoozing <= 1'b0;
      snz_cnt  <= '0;
    end else if (cancel || ring_start) begin
      snoozing <= 1'b0;
      snz_cnt  <= '0;
    end else if (snooze_start) begin
      snoozing <= 1'b1;
      snz_cnt  <= '0;
    end else if (snoozing && sec_tick) begin
      snoozing <= !snooze_expire;
      snz_cnt  <= snooze_expire ? '0 : snz_cnt + 10'd1;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze_start, cancel, ring_start, 10'(SNOOZE_TICKS)};
  assign snooze_expire = 1'b0;
`endif

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode FSM, adjust pulses, arm/ring control and digit blinking.
// Optional snooze on center while ringing is built when ALARM_SNOOZE_EN is defined.
import alarm_pkg::*;

module alarm_mode_ctrl #(
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 120
) (
  input logic              clk,
  input logic              rst,
  alarm_mode_ctrl_if.slave bus
);

  mode_t state, state_nx;
  logic  armed, ring, ring_nx, tm_prev, phase;
  logic  en_th_p1, en_tm_p1, en_ah_p1, en_am_p1, updown_p1;
  logic  any_btn, act, lr_cmd, ud_cmd, adj, arm_set, arm_clear, trig;
  logic  ring_start, snooze_start, ring_expire, snooze_expire;

  // While ringing every button is swallowed; otherwise center > left/right > up/down
  assign any_btn = bus.up | bus.down | bus.left | bus.right | bus.center;
  assign act     = !ring;
  assign lr_cmd  = act && !bus.center && (bus.left ^ bus.right);
  assign ud_cmd  = act && !bus.center && !(bus.left ^ bus.right) && (bus.up ^ bus.down);
  assign adj     = ud_cmd && (state != MODE_N);

  assign arm_set   = ud_cmd && (state == MODE_N) && bus.up;
  assign arm_clear = ud_cmd && (state == MODE_N) && bus.down && armed;
  assign trig      = bus.time_match && !tm_prev && armed && (state == MODE_N) && !ring;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MODE_N;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (act && bus.center) begin
      state_nx = (state == MODE_N) ? MODE_TH : MODE_N;
    end else if (lr_cmd && bus.right) begin
      case (state)
        MODE_TH: state_nx = MODE_TM;
        MODE_TM: state_nx = MODE_AH;
        MODE_AH: state_nx = MODE_AM;
        MODE_AM: state_nx = MODE_TH;
        default: state_nx = state;
      endcase
    end else if (lr_cmd) begin
      case (state)
        MODE_TH: state_nx = MODE_AM;
        MODE_TM: state_nx = MODE_TH;
        MODE_AH: state_nx = MODE_TM;
        MODE_AM: state_nx = MODE_AH;
        default: state_nx = state;
      endcase
    end
  end

  // Stage p1: adjust pulse and direction, one cycle after the button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_th_p1  <= 1'b0;
      en_tm_p1  <= 1'b0;
      en_ah_p1  <= 1'b0;
      en_am_p1  <= 1'b0;
      updown_p1 <= 1'b0;
    end else begin
      en_th_p1 <= adj && (state == MODE_TH);
      en_tm_p1 <= adj && (state == MODE_TM);
      en_ah_p1 <= adj && (state == MODE_AH);
      en_am_p1 <= adj && (state == MODE_AM);
      if (adj) updown_p1 <= bus.up;
    end
  end

  always_comb begin
    ring_nx = ring;
    if (arm_clear)
      ring_nx = 1'b0;
    else if (ring && (any_btn || ring_expire))
      ring_nx = 1'b0;
    else if (!ring && (trig || (snooze_expire && armed)))
      ring_nx = 1'b1;
  end

  assign ring_start = !ring && ring_nx;
`ifdef ALARM_SNOOZE_EN
  assign snooze_start = ring && bus.center;
`else
  assign snooze_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b0;
      ring    <= 1'b0;
      tm_prev <= 1'b0;
      phase   <= 1'b0;
    end else begin
      if (arm_set)        armed <= 1'b1;
      else if (arm_clear) armed <= 1'b0;
      ring    <= ring_nx;
      tm_prev <= bus.time_match;
      if (bus.sec_tick) phase <= !phase;
    end
  end

  alarm_ring_timer #(
    .RING_TICKS   (RING_TICKS),
    .SNOOZE_TICKS (SNOOZE_TICKS)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .sec_tick      (bus.sec_tick),
    .ring          (ring),
    .ring_start    (ring_start),
    .snooze_start  (snooze_start),
    .cancel        (arm_clear),
    .ring_expire   (ring_expire),
    .snooze_expire (snooze_expire)
  );

  assign bus.mode       = state;
  assign bus.en_th      = en_th_p1;
  assign bus.en_tm      = en_tm_p1;
  assign bus.en_ah      = en_ah_p1;
  assign bus.en_am      = en_am_p1;
  assign bus.updown     = updown_p1;
  assign bus.time_run   = (state == MODE_N) || (state == MODE_AH) || (state == MODE_AM);
  assign bus.armed      = armed;
  assign bus.ring       = ring;
  assign bus.blink_mask = phase ? digit_mask(state) : MASK_NONE;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: vector table, directed alarm sequences and random run vs. a reference model.
module tb_alarm_mode_ctrl;

  localparam int RING_T = 60;
  localparam int SNZ_T  = 120;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alarm_mode_ctrl_if ifc ();

  alarm_mode_ctrl #(.RING_TICKS(RING_T), .SNOOZE_TICKS(SNZ_T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int passes = 0;

  // Reference model state: modes as integers 0..4, en as the mode code that was adjusted (0 = none)
  int m_mode, m_en, m_rcnt, m_scnt;
  bit m_armed, m_ring, m_snz, m_phase, m_tmp, m_ud;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_en = 0; m_rcnt = 0; m_scnt = 0;
    m_armed = 0; m_ring = 0; m_snz = 0; m_phase = 0; m_tmp = 0; m_ud = 0;
  endtask

  task automatic model_next(input bit u, d, l, r, c, t, tm);
    bit any, rise;
    any  = u | d | l | r | c;
    rise = tm && !m_tmp;
    m_tmp = tm;
    m_en = 0;
    if (t) m_phase = !m_phase;
    if (m_ring) begin
      if (any) begin
        m_ring = 0;
`ifdef ALARM_SNOOZE_EN
        if (c) begin m_snz = 1; m_scnt = 0; end
`endif
      end else if (t) begin
        m_rcnt++;
        if (m_rcnt == RING_T) m_ring = 0;
      end
    end else begin
      bit armed_old;
      int mode_old;
      armed_old = m_armed;
      mode_old  = m_mode;
      if (c) m_mode = (m_mode == 0) ? 1 : 0;
      else if (l ^ r) begin
        if (m_mode != 0) m_mode = r ? (m_mode % 4) + 1 : ((m_mode + 2) % 4) + 1;
      end else if (u ^ d) begin
        if (m_mode == 0) m_armed = u;
        else begin m_en = m_mode; m_ud = u; end
      end
      if (m_snz && t) begin
        m_scnt++;
        if (m_scnt == SNZ_T) begin m_snz = 0; if (m_armed) m_ring = 1; end
      end
      if (rise && armed_old && mode_old == 0 && m_armed) m_ring = 1;
      if (!m_armed) m_snz = 0;
      if (m_ring) begin m_rcnt = 0; m_snz = 0; end
    end
  endtask

  task automatic compare_all();
    logic [3:0] en_exp, mask_exp;
    en_exp = (m_en == 0) ? 4'b0000 : 4'(8 >> (m_en - 1));
    mask_exp = !m_phase ? 4'b0000 :
               (m_mode == 1 || m_mode == 3) ? 4'b1100 :
               (m_mode == 2 || m_mode == 4) ? 4'b0011 : 4'b0000;
    check("mode", ifc.mode, m_mode);
    check("en", {ifc.en_th, ifc.en_tm, ifc.en_ah, ifc.en_am}, en_exp);
    if (m_en != 0) check("updown", ifc.updown, m_ud);
    check("time_run", ifc.time_run, (m_mode == 0 || m_mode >= 3));
    check("armed", ifc.armed, m_armed);
    check("ring", ifc.ring, m_ring);
    check("blink_mask", ifc.blink_mask, mask_exp);
  endtask

  task automatic step(input bit u, d, l, r, c, t, tm);
    @(negedge clk);
    ifc.up = u; ifc.down = d; ifc.left = l; ifc.right = r; ifc.center = c;
    ifc.sec_tick = t; ifc.time_match = tm;
    model_next(u, d, l, r, c, t, tm);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input bit tm);
    @(negedge clk);
    #2;
    rst = 1'b0;
    ifc.up = 0; ifc.down = 0; ifc.left = 0; ifc.right = 0; ifc.center = 0;
    ifc.sec_tick = 0; ifc.time_match = tm;
    #1;
    model_reset();
    compare_all();
    check("rst_updown", ifc.updown, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [4:0] btn;   // {up, down, left, right, center}
    int         mode;
    logic [3:0] en;    // {th, tm, ah, am}
    bit         ud;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{5'b00001, 1, 4'b0000, 0};
    vecs[1]  = '{5'b00010, 2, 4'b0000, 0};
    vecs[2]  = '{5'b00010, 3, 4'b0000, 0};
    vecs[3]  = '{5'b00010, 4, 4'b0000, 0};
    vecs[4]  = '{5'b00010, 1, 4'b0000, 0};
    vecs[5]  = '{5'b00100, 4, 4'b0000, 0};
    vecs[6]  = '{5'b00001, 0, 4'b0000, 0};
    vecs[7]  = '{5'b00001, 1, 4'b0000, 0};
    vecs[8]  = '{5'b00010, 2, 4'b0000, 0};
    vecs[9]  = '{5'b10000, 2, 4'b0100, 1};
    vecs[10] = '{5'b01000, 2, 4'b0100, 0};
    vecs[11] = '{5'b11000, 2, 4'b0000, 0};
    vecs[12] = '{5'b00100, 1, 4'b0000, 0};
    vecs[13] = '{5'b10001, 0, 4'b0000, 0};
    vecs[14] = '{5'b00110, 0, 4'b0000, 0};
    vecs[15] = '{5'b00001, 1, 4'b0000, 0};
    vecs[16] = '{5'b00110, 1, 4'b0000, 0};
    vecs[17] = '{5'b10010, 2, 4'b0000, 0};
    vecs[18] = '{5'b10000, 2, 4'b0100, 1};
    vecs[19] = '{5'b00001, 0, 4'b0000, 0};

    ifc.up = 0; ifc.down = 0; ifc.left = 0; ifc.right = 0; ifc.center = 0;
    ifc.sec_tick = 0; ifc.time_match = 0;
    model_reset();
    do_reset(1'b0);

    // Mode walk, adjust pulses and priority corners
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].btn[4], vecs[i].btn[3], vecs[i].btn[2], vecs[i].btn[1], vecs[i].btn[0], 0, 0);
      check($sformatf("vec%0d_mode", i), ifc.mode, vecs[i].mode);
      check($sformatf("vec%0d_en", i), {ifc.en_th, ifc.en_tm, ifc.en_ah, ifc.en_am}, vecs[i].en);
      if (vecs[i].en != 0) check($sformatf("vec%0d_updown", i), ifc.updown, vecs[i].ud);
    end

    // Arm, ring on time_match edge, auto-stop after RING_T ticks, no retrigger on held level
    step(1, 0, 0, 0, 0, 0, 0);
    check("arm_set", ifc.armed, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("ring_on", ifc.ring, 1);
    for (int i = 0; i < RING_T - 1; i++) step(0, 0, 0, 0, 0, 1, 1);
    check("ring_before_expire", ifc.ring, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    check("ring_expired", ifc.ring, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
    check("no_retrigger", ifc.ring, 0);

    // Right while ringing stops ring without changing mode
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("ring_again", ifc.ring, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    check("right_stops_ring", ifc.ring, 0);
    check("right_mode_kept", ifc.mode, 0);

    // Down while ringing is consumed: ring stops, alarm stays armed
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    check("down_consumed_ring", ifc.ring, 0);
    check("down_consumed_armed", ifc.armed, 1);

    // Center while ringing
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    check("center_stops_ring", ifc.ring, 0);
    check("center_mode_kept", ifc.mode, 0);
`ifdef ALARM_SNOOZE_EN
    for (int i = 0; i < SNZ_T - 1; i++) step(0, 0, 0, 0, 0, 1, 1);
    check("snooze_waiting", ifc.ring, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check("snooze_rering", ifc.ring, 1);
    step(0, 0, 0, 1, 0, 0, 1);
`else
    for (int i = 0; i < SNZ_T + 10; i++) step(0, 0, 0, 0, 0, 1, 1);
    check("no_snooze_rering", ifc.ring, 0);
`endif

    // Reset in the middle of a ring with time_match held high
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("ring_before_reset", ifc.ring, 1);
    do_reset(1'b1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    check("no_ring_after_reset", ifc.ring, 0);

    // Random run against the reference model
    begin
      bit tmr;
      tmr = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(19) == 0) tmr = !tmr;
        step($urandom_range(7) == 0, $urandom_range(11) == 0, $urandom_range(13) == 0,
             $urandom_range(13) == 0, $urandom_range(15) == 0, $urandom_range(2) == 0, tmr);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
